// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage that feeds the 16-bit ALU.
//
// Accepts one instruction per cycle over in_valid/in_ready. It reads both source
// registers from the register file in the same cycle and decodes the ALU op. It
// then builds the operands (register or extended immediate) and holds the result
// in a single-entry issue register that drives the execute stage.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   When defined, fwd_valid/fwd_addr/fwd_data let a pending write-back value
//   replace register-file read data for matching register sources.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        instruction handshake
//   in_instr                 16-bit instruction word
//   rf_raddr_a/b, rf_rdata_a/b  register-file read port (combinational)
//   flush                    drop held and incoming instruction
//   ex_valid/ex_ready        issue-register handshake to execute
//   alu_op, srcdata_a/b      ALU operation and operands
//   wb_addr                  destination register
//   illegal                  one-cycle pulse when an unsupported instruction is consumed
module alu_issue #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3   // instruction register fields are 3 bits wide
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    output logic [RW-1:0] rf_raddr_a,
    output logic [RW-1:0] rf_raddr_b,
    input  logic [DW-1:0] rf_rdata_a,
    input  logic [DW-1:0] rf_rdata_b,
`ifdef ALU_ISSUE_FWD_EN
    input  logic          fwd_valid,
    input  logic [RW-1:0] fwd_addr,
    input  logic [DW-1:0] fwd_data,
`endif
    input  logic          flush,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] srcdata_a,
    output logic [DW-1:0] srcdata_b,
    output logic [RW-1:0] wb_addr,
    output logic          illegal
);

    logic [4:0]    major;
    logic [RW-1:0] rx, ry, rz;
    logic [2:0]    shamt;

    assign major = in_instr[15:11];
    assign rx    = in_instr[10:8];
    assign ry    = in_instr[7:5];
    assign rz    = in_instr[4:2];
    assign shamt = in_instr[4:2];

    // Decode results
    logic          dec_legal;
    logic          dec_shift;
    logic          dec_b_imm;
    logic [3:0]    dec_op;
    logic [DW-1:0] dec_imm;
    logic [RW-1:0] dec_wb;

    always_comb begin
        dec_legal = 1'b0;
        dec_shift = 1'b0;
        dec_b_imm = 1'b0;
        dec_op    = 4'b0000;
        dec_imm   = '0;
        dec_wb    = rx;
        case (major)
            5'b11100: begin  // ADDU
                dec_legal = (in_instr[1:0] == 2'b01);
                dec_wb    = rz;
            end
            5'b11101: begin  // AND / OR
                if (in_instr[4:0] == 5'b01100) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b0010;
                end else if (in_instr[4:0] == 5'b01101) begin
                    dec_legal = 1'b1;
                    dec_op    = 4'b0011;
                end
            end
            5'b00110: begin  // SLL / SRL / SRA
                dec_shift = 1'b1;
                dec_b_imm = 1'b1;
                // A zero shamt field encodes a shift by 8.
                dec_imm   = (shamt == 3'd0) ? DW'(8) : DW'(shamt);
                unique case (in_instr[1:0])
                    2'b00: begin dec_legal = 1'b1; dec_op = 4'b0100; end
                    2'b10: begin dec_legal = 1'b1; dec_op = 4'b0101; end
                    2'b11: begin dec_legal = 1'b1; dec_op = 4'b0110; end
                    default: dec_legal = 1'b0;
                endcase
            end
            5'b01001: begin  // ADDIU
                dec_legal = 1'b1;
                dec_b_imm = 1'b1;
                dec_imm   = {{(DW-8){in_instr[7]}}, in_instr[7:0]};
            end
            5'b01000: begin  // ADDIU3
                dec_legal = !in_instr[4];
                dec_b_imm = 1'b1;
                dec_imm   = {{(DW-4){in_instr[3]}}, in_instr[3:0]};
                dec_wb    = ry;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Shifts take their data operand from ry, so port A follows it.
    assign rf_raddr_a = dec_shift ? ry : rx;
    assign rf_raddr_b = ry;

    logic [DW-1:0] reg_a, reg_b;
`ifdef ALU_ISSUE_FWD_EN
    assign reg_a = (fwd_valid && fwd_addr == rf_raddr_a) ? fwd_data : rf_rdata_a;
    assign reg_b = (fwd_valid && fwd_addr == rf_raddr_b) ? fwd_data : rf_rdata_b;
`else
    assign reg_a = rf_rdata_a;
    assign reg_b = rf_rdata_b;
`endif

    // Issue register
    logic          ex_valid_q, ex_valid_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [DW-1:0] src_a_q, src_a_d;
    logic [DW-1:0] src_b_q, src_b_d;
    logic [RW-1:0] wb_addr_q, wb_addr_d;
    logic          illegal_q, illegal_d;
    logic          accept;

    assign in_ready = !ex_valid_q || ex_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        alu_op_d   = alu_op_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        wb_addr_d  = wb_addr_q;
        illegal_d  = accept && !dec_legal;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept && dec_legal) begin
            ex_valid_d = 1'b1;
            alu_op_d   = dec_op;
            src_a_d    = reg_a;
            src_b_d    = dec_b_imm ? dec_imm : reg_b;
            wb_addr_d  = dec_wb;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            alu_op_q   <= 4'b0000;
            src_a_q    <= '0;
            src_b_q    <= '0;
            wb_addr_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            alu_op_q   <= alu_op_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            wb_addr_q  <= wb_addr_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign alu_op    = alu_op_q;
    assign srcdata_a = src_a_q;
    assign srcdata_b = src_b_q;
    assign wb_addr   = wb_addr_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed cases with literal expectations, then random
// traffic compared every cycle against a behavioural model of the issue stage.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, ex_valid, ex_ready, illegal;
    logic [15:0] in_instr;
    logic [2:0]  rf_raddr_a, rf_raddr_b, wb_addr;
    logic [15:0] rf_rdata_a, rf_rdata_b, srcdata_a, srcdata_b;
    logic [3:0]  alu_op;
    logic        fwd_valid = 1'b0;
    logic [2:0]  fwd_addr = 3'd0;
    logic [15:0] fwd_data = 16'h0;

    logic [7:0][15:0] regs = '0;

    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
`endif
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .alu_op     (alu_op),
        .srcdata_a  (srcdata_a),
        .srcdata_b  (srcdata_b),
        .wb_addr    (wb_addr),
        .illegal    (illegal)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        legal;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  wb;
        logic [2:0]  ra;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] ins, input logic [7:0][15:0] rf,
                                    input logic fv, input logic [2:0] fa,
                                    input logic [15:0] fd);
        dec_t d;
        int   x, y, z, sh;
        logic [15:0] vx, vy;
        x  = int'(ins[10:8]);
        y  = int'(ins[7:5]);
        z  = int'(ins[4:2]);
        sh = int'(ins[4:2]);
        vx = (fv && int'(fa) == x) ? fd : rf[x];
        vy = (fv && int'(fa) == y) ? fd : rf[y];
        d = '0;
        d.ra = ins[10:8];
        case (ins[15:11])
            5'b11100: if (ins[1:0] == 2'b01) begin
                d.legal = 1; d.op = 0; d.a = vx; d.b = vy; d.wb = 3'(z);
            end
            5'b11101: if (ins[4:0] == 5'd12 || ins[4:0] == 5'd13) begin
                d.legal = 1; d.op = (ins[4:0] == 5'd12) ? 4'd2 : 4'd3;
                d.a = vx; d.b = vy; d.wb = 3'(x);
            end
            5'b00110: begin
                d.ra = ins[7:5];
                if (ins[1:0] != 2'b01) begin
                    d.legal = 1;
                    d.op = (ins[1:0] == 2'b00) ? 4'd4 : (ins[1:0] == 2'b10) ? 4'd5 : 4'd6;
                    d.a = vy; d.b = 16'((sh == 0) ? 8 : sh); d.wb = 3'(x);
                end
            end
            5'b01001: begin
                d.legal = 1; d.op = 0; d.a = vx; d.wb = 3'(x);
                d.b = 16'(int'($signed(ins[7:0])));
            end
            5'b01000: if (!ins[4]) begin
                d.legal = 1; d.op = 0; d.a = vx; d.wb = 3'(y);
                d.b = 16'(int'($signed(ins[3:0])));
            end
            default: d.legal = 0;
        endcase
        return d;
    endfunction

    dec_t        m_dec;
    logic        m_valid, m_ill;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_wb;
    logic        m_acc;
`ifdef ALU_ISSUE_FWD_EN
    assign m_dec = decode(in_instr, regs, fwd_valid, fwd_addr, fwd_data);
`else
    assign m_dec = decode(in_instr, regs, 1'b0, 3'd0, 16'h0);
`endif
    assign m_acc = in_valid && (!m_valid || ex_ready) && !flush;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 0; m_ill <= 0; m_op <= 0; m_a <= 0; m_b <= 0; m_wb <= 0;
        end else begin
            m_ill <= m_acc && !m_dec.legal;
            if (flush) m_valid <= 0;
            else if (m_acc && m_dec.legal) begin
                m_valid <= 1; m_op <= m_dec.op; m_a <= m_dec.a; m_b <= m_dec.b;
                m_wb <= m_dec.wb;
            end else if (ex_ready) m_valid <= 0;
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (rst && cmp_en) begin
            check("m.ex_valid", 32'(ex_valid), 32'(m_valid));
            check("m.illegal", 32'(illegal), 32'(m_ill));
            check("m.alu_op", 32'(alu_op), 32'(m_op));
            check("m.srcdata_a", 32'(srcdata_a), 32'(m_a));
            check("m.srcdata_b", 32'(srcdata_b), 32'(m_b));
            check("m.wb_addr", 32'(wb_addr), 32'(m_wb));
            check("m.in_ready", 32'(in_ready), 32'(!m_valid || ex_ready));
            check("m.rf_raddr_a", 32'(rf_raddr_a), 32'(m_dec.ra));
            check("m.rf_raddr_b", 32'(rf_raddr_b), 32'(in_instr[7:5]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string nm, input logic v, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic [2:0] wb);
        check({nm, ".valid"}, 32'(ex_valid), 32'(v));
        check({nm, ".op"}, 32'(alu_op), 32'(op));
        check({nm, ".a"}, 32'(srcdata_a), 32'(a));
        check({nm, ".b"}, 32'(srcdata_b), 32'(b));
        check({nm, ".wb"}, 32'(wb_addr), 32'(wb));
    endtask

    logic [31:0] r;
    logic [15:0] ins;

    initial begin
        rst = 0; in_valid = 0; in_instr = 16'h0; flush = 0; ex_ready = 1;
        step(); step();
        chk_ex("reset", 0, 4'h0, 16'h0, 16'h0, 3'd0);
        check("reset.illegal", 32'(illegal), 0);
        rst = 1;
        step();
        cmp_en = 1;

        // ADDU
        regs[0] = 16'h0003; regs[5] = 16'h0004;
        in_valid = 1; in_instr = 16'hE0A9; #1;
        check("addu.raddr_a", 32'(rf_raddr_a), 0);
        check("addu.raddr_b", 32'(rf_raddr_b), 5);
        step();
        chk_ex("addu", 1, 4'h0, 16'h0003, 16'h0004, 3'd2);

        // SLL with shamt 0 -> 8
        regs[1] = 16'h0001; in_instr = 16'h3020; #1;
        check("sll.raddr_a", 32'(rf_raddr_a), 1);
        step();
        chk_ex("sll", 1, 4'h4, 16'h0001, 16'h0008, 3'd0);

        // ADDIU with -1
        regs[1] = 16'h0010; in_instr = 16'h49FF;
        step();
        chk_ex("addiu", 1, 4'h0, 16'h0010, 16'hFFFF, 3'd1);

        // Back-pressure
        ex_ready = 0; in_instr = 16'hE0A9; #1;
        check("hold.in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ex("hold", 1, 4'h0, 16'h0010, 16'hFFFF, 3'd1);
            check("hold.in_ready", 32'(in_ready), 0);
        end
        ex_ready = 1; #1;
        check("release.in_ready", 32'(in_ready), 1);
        step();
        chk_ex("release", 1, 4'h0, 16'h0003, 16'h0004, 3'd2);

        // Illegal pulse
        in_valid = 0; step();
        check("drain.valid", 32'(ex_valid), 0);
        in_valid = 1; in_instr = 16'hF800; step();
        check("illegal.pulse", 32'(illegal), 1);
        check("illegal.valid", 32'(ex_valid), 0);
        in_valid = 0; step();
        check("illegal.one_cycle", 32'(illegal), 0);
        flush = 1; in_valid = 1; step();
        check("illegal.flushed", 32'(illegal), 0);
        flush = 0;

        // Flush a held op
        in_instr = 16'hE0A9; ex_ready = 0; step();
        check("flush.loaded", 32'(ex_valid), 1);
        in_valid = 0; flush = 1; step();
        check("flush.valid", 32'(ex_valid), 0);
        flush = 0;

        // Reset during hold
        in_valid = 1; step();
        check("rsthold.loaded", 32'(ex_valid), 1);
        in_valid = 0; #2; rst = 0; #1;
        check("rsthold.valid", 32'(ex_valid), 0);
        check("rsthold.a", 32'(srcdata_a), 0);
        step(); rst = 1; ex_ready = 1;
        step();

`ifdef ALU_ISSUE_FWD_EN
        regs[1] = 16'h0000; regs[0] = 16'h1234;
        fwd_valid = 1; fwd_addr = 3'd1; fwd_data = 16'h00F0;
        in_valid = 1; in_instr = 16'hE82C; step();
        chk_ex("fwd", 1, 4'h2, 16'h1234, 16'h00F0, 3'd0);
        fwd_valid = 0; in_valid = 0; step();
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0: ins = {5'b11100, r[10:2], 2'b01};
                1: ins = {5'b11101, r[10:5], 5'b01100};
                2: ins = {5'b11101, r[10:5], 5'b01101};
                3: ins = {5'b00110, r[10:0]};
                4: ins = {5'b01001, r[10:0]};
                5: ins = {5'b01000, r[10:0]};
                default: ins = r[15:0];
            endcase
            in_instr = ins;
            in_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
`ifdef ALU_ISSUE_FWD_EN
            fwd_valid = ($urandom_range(0, 2) == 0);
            fwd_addr  = 3'($urandom_range(0, 7));
            fwd_data  = 16'($urandom);
`endif
            step();
        end

        in_valid = 0; flush = 0; ex_ready = 1;
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that feeds the 16-bit ALU. It accepts one 16-bit instruction per cycle over a valid/ready handshake and reads its two source registers from the register file. It decodes the ALU operation code, builds both operands (register or extended immediate), and holds them in a single-entry pipeline register presented to the execute stage. It sits between instruction fetch and the ALU and is the producer side of the ALU's `OP`/`srcdata_a`/`srcdata_b` interface.

## Interface
Parameters:
- `DW`, 16, datapath width
- `RW`, 3, register address width (8 GPRs)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  stage can accept
- `in_instr`  in  16  instruction word
- `rf_raddr_a` / `rf_raddr_b`  out  3  register-file read addresses, combinational from `in_instr`
- `rf_rdata_a` / `rf_rdata_b`  in  16  register-file read data, same cycle
- `flush`  in  1  discard held and incoming instruction
- `ex_valid`  out  1  issue register holds a valid op
- `ex_ready`  in  1  execute stage accepts
- `alu_op`  out  4  ALU operation code
- `srcdata_a` / `srcdata_b`  out  16  ALU operands
- `wb_addr`  out  3  destination register
- `illegal`  out  1  one-cycle pulse: unsupported instruction consumed

## Operation
- Decode (bits [15:11] major, low bits minor; rx=[10:8], ry=[7:5], rz=[4:2]):
  - ADDU `11100`, [1:0]=01: op 0000, a=R[rx], b=R[ry], dest rz
  - AND `11101`, [4:0]=01100: op 0010, a=R[rx], b=R[ry], dest rx
  - OR `11101`, [4:0]=01101: op 0011, a=R[rx], b=R[ry], dest rx
  - SLL/SRL/SRA `00110`, [1:0]=00/10/11: op 0100/0101/0110, a=R[ry], b=shamt, dest rx; shamt=[4:2] zero-extended, value 0 means 8
  - ADDIU `01001`: op 0000, a=R[rx], b=sign-extended [7:0], dest rx
  - ADDIU3 `01000`, [4]=0: op 0000, a=R[rx], b=sign-extended [3:0], dest ry
  - anything else: illegal
- `rf_raddr_a` = rx, except shifts, where it is ry. `rf_raddr_b` = ry.
- Accept = `in_valid && in_ready && !flush`.
- Legal accept: the issue register loads `alu_op`, operands and `wb_addr`, and `ex_valid` goes to 1.
- Illegal accept: the instruction is consumed, the register is not loaded, and `illegal` = 1 for the next cycle.
- Hold: while `ex_valid && !ex_ready`, all ex outputs stay stable.
- Flush has priority over everything:
  - the next cycle has `ex_valid` = 0
  - a same-cycle `in_valid` is not accepted, and `illegal` is not pulsed for it
- Unused output register fields on load: keep their previous values.

## Timing
- `in_ready` = `!ex_valid || ex_ready` (combinational; allows back-to-back issue at 1 op/cycle).
- Latency: instruction accepted at edge N appears on ex outputs after edge N, i.e. 1 cycle.
- Simultaneous `ex_ready` and a new accept: the old op retires and the new op loads in the same edge.
- Reset (async assert, sync-safe release) drives:
  - `ex_valid`=0, `alu_op`=0000, `srcdata_a`=0, `srcdata_b`=0, `wb_addr`=0, `illegal`=0
- Reset mid-hold discards the held op.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: adds inputs `fwd_valid` (1), `fwd_addr` (3), `fwd_data` (16).
  - At accept, a register source whose address equals `fwd_addr` while `fwd_valid`=1 takes `fwd_data` instead of `rf_rdata_*`.
  - Immediate operands are never forwarded.
- Undefined: these ports do not exist, and operands come only from the register file.

## Test plan
- Reset then ADDU `0xE0A9` (rx=0, ry=5, rz=2), R0=0x0003, R5=0x0004 -> next cycle `ex_valid`=1, op=0000, a=0x0003, b=0x0004, `wb_addr`=2.
- SLL with shamt field 0 (`0x3020`, rx=0, ry=1), R1=0x0001 -> op=0100, a=0x0001, b=0x0008, `wb_addr`=0.
- ADDIU `0x49FF`, R1=0x0010 -> b=0xFFFF (sign-extended -1), op=0000, `wb_addr`=1.
- `ex_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0 and outputs stable; `ex_ready`=1 -> the next op loads on the same edge the old one retires.
- Instruction `0xF800` -> `illegal`=1 for exactly one cycle, `ex_valid` unchanged. Same instruction with `flush`=1 -> no pulse.
- With `ALU_ISSUE_FWD_EN`: AND `0xE82C` (rx=0, ry=1), `fwd_valid`=1, `fwd_addr`=1, `fwd_data`=0x00F0, R1=0x0000 -> `srcdata_b`=0x00F0.
